// File: rtl/multi_main_control.sv
// -----------------------------------------------------------------------------
// multi_main_control
//
// Main control FSM for a multi-cycle MIPS datapath. One instruction is
// sequenced through fetch, decode, execute, memory and writeback states
// (3 to 5 states depending on the opcode). The FSM drives the PC, IR,
// register-file and memory enables, the ALU source muxes and the 2-bit aluop
// consumed by the ALU control block.
//
// Memory handshake (FETCH, MEMREAD, MEMWRITE):
//   The FSM presents memread/memwrite for as long as it sits in a memory
//   state. memready=1 in a cycle means the access completes in that cycle.
//   The FSM then leaves the state on the next rising edge. A per-state wait
//   counter bounds the wait. If it has reached wait_limit and memready is
//   still low, the cycle becomes a timeout cycle. In that cycle the strobes
//   drop, timeout pulses and the FSM returns to FETCH. memready in that same
//   cycle wins over the timeout.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   opcode[5:0]  in   instruction[31:26] from the instruction register
//   memready     in   memory access completes this cycle
//   pcwrite      out  unconditional PC load
//   pcwritecond  out  PC load when the ALU zero flag is set
//   iord         out  memory address select (0 = PC, 1 = aluout)
//   memread      out  memory read request
//   memwrite     out  memory write request
//   irwrite      out  instruction register load
//   memtoreg     out  writeback select (1 = memory data register)
//   regdst       out  destination register (1 = rd, 0 = rt)
//   regwrite     out  register file write
//   alusrca      out  ALU A select (0 = PC, 1 = register A)
//   alusrcb[1:0] out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   aluop[1:0]   out  00 add, 01 sub, 10 decode funct
//   pcsource[1:0]out  00 ALU result, 01 aluout, 10 jump target
//   state[3:0]   out  current FSM state (debug)
//   illegal      out  one-cycle pulse: unsupported opcode seen in DECODE
//   timeout      out  one-cycle pulse: memory wait exceeded wait_limit
//   instcount    out  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multi_main_control #(
  parameter int unsigned wait_limit  = 255,
  parameter int unsigned count_width = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [5:0]             opcode,
  input  logic                   memready,
  output logic                   pcwrite,
  output logic                   pcwritecond,
  output logic                   iord,
  output logic                   memread,
  output logic                   memwrite,
  output logic                   irwrite,
  output logic                   memtoreg,
  output logic                   regdst,
  output logic                   regwrite,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic [1:0]             aluop,
  output logic [1:0]             pcsource,
  output logic [3:0]             state,
  output logic                   illegal,
  output logic                   timeout,
  output logic [count_width-1:0] instcount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] WAIT_LIMIT = 8'(wait_limit);

  state_t                 state_q, state_d;
  logic [7:0]             wait_q, wait_d;
  logic [count_width-1:0] count_q, count_d;

  logic in_wait_state;
  logic timeout_now;
  logic illegal_now;
  logic retire;

  // Strobes before reset gating.
  logic pcwrite_s, pcwritecond_s, memread_s, memwrite_s, irwrite_s, regwrite_s;

  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                         (state_q == S_MEMWRITE);

  // The count has reached the limit and memory still has not answered.
  // A memready in this same cycle takes priority.
  assign timeout_now = in_wait_state && !memready && (wait_q == WAIT_LIMIT);

  // ---------------------------------------------------------------------------
  // Next-state, retire and illegal decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    illegal_now = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (timeout_now)   state_d = S_FETCH;
        else if (memready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            illegal_now = 1'b1;
          end
        endcase
      end
      // Only lw and sw reach MEMADR. The IR is frozen, so opcode is still valid.
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (timeout_now)   state_d = S_FETCH;
        else if (memready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (timeout_now) begin
          state_d = S_FETCH;
        end else if (memready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_RTYPE_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // The FSM stays in a memory state only when memready is low and no timeout
  // fires. In that case the count advances. Every other path leaves the
  // state, and each memory state is entered with a cleared count.
  assign wait_d  = (in_wait_state && !memready && !timeout_now) ?
                   (wait_q + 8'd1) : 8'd0;
  assign count_d = retire ? (count_q + count_width'(1)) : count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode. The only exceptions are the memready-qualified
  // fetch strobes and the timeout suppression of the memory strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    pcwrite_s     = 1'b0;
    pcwritecond_s = 1'b0;
    memread_s     = 1'b0;
    memwrite_s    = 1'b0;
    irwrite_s     = 1'b0;
    regwrite_s    = 1'b0;
    iord          = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    aluop         = 2'b00;
    pcsource      = 2'b00;
    case (state_q)
      S_FETCH: begin
        memread_s = !timeout_now;
        irwrite_s = memready;
        pcwrite_s = memready;
        alusrcb   = 2'b01;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD: begin
        memread_s = !timeout_now;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWRITE: begin
        memwrite_s = !timeout_now;
        iord       = 1'b1;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPE_WB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca       = 1'b1;
        aluop         = 2'b01;
        pcwritecond_s = 1'b1;
        pcsource      = 2'b01;
      end
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDI_WB: begin
        regwrite_s = 1'b1;
      end
      S_JUMP: begin
        pcwrite_s = 1'b1;
        pcsource  = 2'b10;
      end
      default: ;
    endcase
  end

  // reset_n gates the strobes asynchronously. The state register already
  // holds FETCH during reset, so the FETCH memread and the memready-driven
  // irwrite/pcwrite must not leak through.
  assign pcwrite     = pcwrite_s     & reset_n;
  assign pcwritecond = pcwritecond_s & reset_n;
  assign memread     = memread_s     & reset_n;
  assign memwrite    = memwrite_s    & reset_n;
  assign irwrite     = irwrite_s     & reset_n;
  assign regwrite    = regwrite_s    & reset_n;
  assign illegal     = illegal_now   & reset_n;
  assign timeout     = timeout_now   & reset_n;

  assign state     = state_q;
  assign instcount = count_q;

endmodule

// File: tb/tb_multi_main_control.sv
// -----------------------------------------------------------------------------
// tb_multi_main_control
//
// Bench for multi_main_control, with wait_limit reduced to 4.
//
// The driver applies inputs for one cycle #1 after each rising edge. It pushes
// that cycle's hand-derived expected output vector into exp_q. The monitor pops
// one entry on every falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multi_main_control;

  localparam int unsigned WAIT_LIMIT = 4;
  localparam int unsigned CW         = 16;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]    st;
    logic          pcwrite;
    logic          pcwritecond;
    logic          iord;
    logic          memread;
    logic          memwrite;
    logic          irwrite;
    logic          memtoreg;
    logic          regdst;
    logic          regwrite;
    logic          alusrca;
    logic [1:0]    alusrcb;
    logic [1:0]    aluop;
    logic [1:0]    pcsource;
    logic          illegal;
    logic          timeout;
    logic [CW-1:0] cnt;
  } obs_t;

  localparam int W = $bits(obs_t);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n;
  logic [5:0] opcode;
  logic memready;

  always #5 clk = ~clk;

  logic          pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic          memtoreg, regdst, regwrite, alusrca, illegal, timeout;
  logic [1:0]    alusrcb, aluop, pcsource;
  logic [3:0]    state;
  logic [CW-1:0] instcount;

  multi_main_control #(
    .wait_limit (WAIT_LIMIT),
    .count_width(CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .memready   (memready),
    .pcwrite    (pcwrite),
    .pcwritecond(pcwritecond),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsource   (pcsource),
    .state      (state),
    .illegal    (illegal),
    .timeout    (timeout),
    .instcount  (instcount)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // Control table for each state, taken from the state list of the design.
  // mr is the cycle's memready, to marks a timeout cycle, il an illegal
  // cycle, and rst a cycle spent with reset_n low.
  function automatic obs_t exp_obs(input logic [3:0] st, input logic mr,
                                   input logic to, input logic il,
                                   input logic [CW-1:0] cnt, input logic rst);
    obs_t o;
    o = '0;
    o.st = st;
    o.illegal = il;
    o.timeout = to;
    o.cnt = cnt;
    case (st)
      4'd0:  begin o.memread = !to; o.irwrite = mr; o.pcwrite = mr; o.alusrcb = 2'b01; end
      4'd1:  o.alusrcb = 2'b11;
      4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      4'd3:  begin o.memread = !to; o.iord = 1'b1; end
      4'd4:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
      4'd5:  begin o.memwrite = !to; o.iord = 1'b1; end
      4'd6:  begin o.alusrca = 1'b1; o.aluop = 2'b10; end
      4'd7:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
      4'd8:  begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcwritecond = 1'b1; o.pcsource = 2'b01; end
      4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      4'd10: o.regwrite = 1'b1;
      4'd11: begin o.pcwrite = 1'b1; o.pcsource = 2'b10; end
      default: ;
    endcase
    if (rst) begin
      o.pcwrite = 1'b0; o.pcwritecond = 1'b0; o.memread = 1'b0;
      o.memwrite = 1'b0; o.irwrite = 1'b0; o.regwrite = 1'b0;
      o.illegal = 1'b0; o.timeout = 1'b0;
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic [3:0] st, input logic mr,
                       input logic [5:0] op, input logic to, input logic il,
                       input logic [CW-1:0] cnt, input string nm);
    reset_n  = !rst;
    memready = mr;
    opcode   = op;
    exp_q.push_back(exp_obs(st, mr, to, il, cnt, rst));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] st, input logic mr, input logic [5:0] op,
                     input logic [CW-1:0] cnt, input string nm);
    drive(1'b0, st, mr, op, 1'b0, 1'b0, cnt, nm);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  got, want;
      string nm;
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
              memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
              illegal, timeout, instcount};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got st=%0d pcw=%b pcwc=%b iord=%b mrd=%b mwr=%b irw=%b m2r=%b rdst=%b rw=%b asa=%b asb=%b aop=%b psrc=%b ill=%b to=%b cnt=%0d ; required st=%0d pcw=%b pcwc=%b iord=%b mrd=%b mwr=%b irw=%b m2r=%b rdst=%b rw=%b asa=%b asb=%b aop=%b psrc=%b ill=%b to=%b cnt=%0d",
                 nm, got.st, got.pcwrite, got.pcwritecond, got.iord, got.memread,
                 got.memwrite, got.irwrite, got.memtoreg, got.regdst, got.regwrite,
                 got.alusrca, got.alusrcb, got.aluop, got.pcsource, got.illegal,
                 got.timeout, got.cnt,
                 want.st, want.pcwrite, want.pcwritecond, want.iord, want.memread,
                 want.memwrite, want.irwrite, want.memtoreg, want.regdst, want.regwrite,
                 want.alusrca, want.alusrcb, want.aluop, want.pcsource, want.illegal,
                 want.timeout, want.cnt);
      end
    end
  end

  // Watchdog: the directed sequence is a few hundred ns long.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n  = 1'b0;
    memready = 1'b1;
    opcode   = OP_LW;
    @(posedge clk);
    #1;

    // Reset: FETCH mux values, strobes forced low even with memready=1.
    drive(1'b1, 4'd0, 1'b1, OP_LW, 1'b0, 1'b0, 16'd0, "reset_hold0");
    drive(1'b1, 4'd0, 1'b1, OP_LW, 1'b0, 1'b0, 16'd0, "reset_hold1");

    // lw, memready always high: 0,1,2,3,4 then instcount=1.
    cyc(4'd0, 1'b1, OP_LW, 16'd0, "lw_fetch");
    cyc(4'd1, 1'b1, OP_LW, 16'd0, "lw_decode");
    cyc(4'd2, 1'b1, OP_LW, 16'd0, "lw_memadr");
    cyc(4'd3, 1'b1, OP_LW, 16'd0, "lw_memread");
    cyc(4'd4, 1'b1, OP_LW, 16'd0, "lw_memwb");

    // R-type then beq.
    cyc(4'd0, 1'b1, OP_R,   16'd1, "r_fetch");
    cyc(4'd1, 1'b1, OP_R,   16'd1, "r_decode");
    cyc(4'd6, 1'b1, OP_R,   16'd1, "r_ex");
    cyc(4'd7, 1'b1, OP_R,   16'd1, "r_wb");
    cyc(4'd0, 1'b1, OP_BEQ, 16'd2, "beq_fetch");
    cyc(4'd1, 1'b1, OP_BEQ, 16'd2, "beq_decode");
    cyc(4'd8, 1'b1, OP_BEQ, 16'd2, "beq_branch");

    // sw with memready low for 3 cycles in MEMWRITE.
    cyc(4'd0, 1'b1, OP_SW, 16'd3, "sw_fetch");
    cyc(4'd1, 1'b1, OP_SW, 16'd3, "sw_decode");
    cyc(4'd2, 1'b1, OP_SW, 16'd3, "sw_memadr");
    cyc(4'd5, 1'b0, OP_SW, 16'd3, "sw_wait1");
    cyc(4'd5, 1'b0, OP_SW, 16'd3, "sw_wait2");
    cyc(4'd5, 1'b0, OP_SW, 16'd3, "sw_wait3");
    cyc(4'd5, 1'b1, OP_SW, 16'd3, "sw_done");

    // Fetch timeout: 4 waiting cycles, then the timeout cycle.
    for (int i = 0; i < 4; i++) cyc(4'd0, 1'b0, OP_J, 16'd4, $sformatf("fto_wait%0d", i));
    drive(1'b0, 4'd0, 1'b0, OP_J, 1'b1, 1'b0, 16'd4, "fto_timeout");
    cyc(4'd0, 1'b0, OP_J, 16'd4, "fto_refetch_wait");
    cyc(4'd0, 1'b1, OP_J, 16'd4, "j_fetch");
    cyc(4'd1, 1'b1, OP_J, 16'd4, "j_decode");
    cyc(4'd11, 1'b1, OP_J, 16'd4, "j_jump");

    // lw where memready arrives on the cycle the count hits the limit.
    cyc(4'd0, 1'b1, OP_LW, 16'd5, "lwb_fetch");
    cyc(4'd1, 1'b1, OP_LW, 16'd5, "lwb_decode");
    cyc(4'd2, 1'b1, OP_LW, 16'd5, "lwb_memadr");
    for (int i = 0; i < 4; i++) cyc(4'd3, 1'b0, OP_LW, 16'd5, $sformatf("lwb_wait%0d", i));
    cyc(4'd3, 1'b1, OP_LW, 16'd5, "lwb_ready_at_limit");
    cyc(4'd4, 1'b1, OP_LW, 16'd5, "lwb_memwb");

    // sw timing out in MEMWRITE: no retire.
    cyc(4'd0, 1'b1, OP_SW, 16'd6, "swto_fetch");
    cyc(4'd1, 1'b1, OP_SW, 16'd6, "swto_decode");
    cyc(4'd2, 1'b1, OP_SW, 16'd6, "swto_memadr");
    for (int i = 0; i < 4; i++) cyc(4'd5, 1'b0, OP_SW, 16'd6, $sformatf("swto_wait%0d", i));
    drive(1'b0, 4'd5, 1'b0, OP_SW, 1'b1, 1'b0, 16'd6, "swto_timeout");

    // Illegal opcode.
    cyc(4'd0, 1'b1, OP_BAD, 16'd6, "ill_fetch");
    drive(1'b0, 4'd1, 1'b1, OP_BAD, 1'b0, 1'b1, 16'd6, "ill_decode");

    // addi.
    cyc(4'd0, 1'b1, OP_ADD, 16'd6, "addi_fetch");
    cyc(4'd1, 1'b1, OP_ADD, 16'd6, "addi_decode");
    cyc(4'd9, 1'b1, OP_ADD, 16'd6, "addi_ex");
    cyc(4'd10, 1'b1, OP_ADD, 16'd6, "addi_wb");

    // Reset asserted during MEMREAD aborts at once and clears instcount.
    cyc(4'd0, 1'b1, OP_LW, 16'd7, "rlw_fetch");
    cyc(4'd1, 1'b1, OP_LW, 16'd7, "rlw_decode");
    cyc(4'd2, 1'b1, OP_LW, 16'd7, "rlw_memadr");
    cyc(4'd3, 1'b0, OP_LW, 16'd7, "rlw_memread");
    drive(1'b1, 4'd0, 1'b1, OP_LW, 1'b0, 1'b0, 16'd0, "rlw_reset0");
    drive(1'b1, 4'd0, 1'b1, OP_LW, 1'b0, 1'b0, 16'd0, "rlw_reset1");
    cyc(4'd0, 1'b1, OP_J, 16'd0, "post_fetch");
    cyc(4'd1, 1'b1, OP_J, 16'd0, "post_decode");
    cyc(4'd11, 1'b1, OP_J, 16'd0, "post_jump");
    cyc(4'd0, 1'b0, OP_J, 16'd1, "post_final_fetch");

    // Let the monitor drain the queue.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_main_control.md
Name: multi_main_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences one instruction over 3–5 states: fetch, decode, execute, memory, writeback.
- Drives register/memory/PC enables, ALU source muxes and the 2-bit aluop consumed by the ALU control block.
- Waits on a memory-ready handshake, has a memory-wait timeout, and keeps a retired-instruction counter.

Parameters:
- wait_limit, 255: maximum cycles spent waiting for memready in one memory state before timeout; range 1..255.
- count_width, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode  input  6  instruction[31:26], taken from the instruction register.
- memready  input  1  memory access completes in this cycle.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load if the ALU zero flag is set.
- iord  output  1  memory address select: 0 = PC, 1 = aluout.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- irwrite  output  1  instruction register load.
- memtoreg  output  1  writeback select: 1 = memory data register.
- regdst  output  1  destination register: 1 = rd, 0 = rt.
- regwrite  output  1  register file write.
- alusrca  output  1  ALU A input: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B input: 00 = register B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- aluop  output  2  00 = add, 01 = sub, 10 = decode funct.
- pcsource  output  2  PC source: 00 = ALU result, 01 = aluout, 10 = jump target.
- state  output  4  current state, for debug.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- timeout  output  1  one-cycle pulse on a memory-wait timeout.
- instcount  output  count_width  number of retired instructions.

Behaviour:
- Reset: reset is asynchronous and active-low; on reset_n low, state=FETCH(0), wait counter=0, instcount=0, illegal=0, timeout=0.
- While reset_n is low, every strobe (pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite) is forced to 0.
- Mux/aluop outputs during reset take their FETCH values: alusrca=0, alusrcb=01, aluop=00, pcsource=00, iord=0.
- All control outputs are Moore outputs decoded from state; the exception is fetch/memory strobes qualified by memready as noted below.
- Any output not listed for a state is 0.
- States (encoding in brackets):
  - FETCH[0]: memread=1, alusrcb=01, aluop=00.
    - irwrite=pcwrite=memready.
    - Stay while memready=0; on memready go to DECODE.
  - DECODE[1]: alusrcb=11, aluop=00 (branch target into aluout). Next state by opcode:
    - 000000 -> RTYPE_EX
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 001000 -> ADDI_EX
    - 000010 -> JUMP
    - any other opcode -> FETCH with illegal=1 for one cycle; instcount is not incremented.
  - MEMADR[2]: alusrca=1, alusrcb=10, aluop=00. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD[3]: memread=1, iord=1. Wait for memready, then MEMWB.
  - MEMWB[4]: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
  - MEMWRITE[5]: memwrite=1, iord=1. Wait for memready, then FETCH.
  - RTYPE_EX[6]: alusrca=1, alusrcb=00, aluop=10. Then RTYPE_WB.
  - RTYPE_WB[7]: regwrite=1, regdst=1, memtoreg=0. Then FETCH.
  - BRANCH[8]: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Then FETCH.
  - ADDI_EX[9]: alusrca=1, alusrcb=10, aluop=00. Then ADDI_WB.
  - ADDI_WB[10]: regwrite=1, regdst=0, memtoreg=0. Then FETCH.
  - JUMP[11]: pcwrite=1, pcsource=10. Then FETCH.
  - Encodings 12–15 are unreachable; if entered, go to FETCH on the next edge with no strobes asserted.
- Latency: j and beq take 3 cycles; R-type and addi take 4 cycles; sw takes 4 cycles; lw takes 5 cycles. Each memory state adds one cycle per cycle of memready low.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD and MEMWRITE.
  - Increments each cycle the FSM stays in one of those states with memready=0.
  - When it reaches wait_limit with memready still 0: timeout=1 for one cycle, strobes drop, next state=FETCH.
  - A timeout in FETCH re-fetches from the same PC, because pcwrite was never asserted.
  - memready arriving in the same cycle the count reaches wait_limit wins: normal progress, no timeout.
- instcount:
  - Increments by 1 on the edge leaving MEMWB, MEMWRITE (with memready), RTYPE_WB, BRANCH, ADDI_WB or JUMP.
  - Wraps modulo 2^count_width.
  - Not incremented on illegal or timeout.
- Reset asserted mid-instruction aborts immediately to FETCH; no partial writeback follows.
- opcode is sampled only in DECODE and MEMADR; the IR is held stable by irwrite=0 outside FETCH.

Test Plan:
- Release reset, memready=1, opcode=100011 (lw) -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; instcount=1.
- R-type opcode 000000 then beq 000100 -> aluop=10 in state 6 with regwrite/regdst in 7; aluop=01 and pcwritecond=1 in state 8; instcount=2 after 7 cycles.
- sw with memready low for 3 cycles in MEMWRITE -> memwrite held 4 cycles, iord=1; exit to FETCH on the memready cycle.
- wait_limit=4, memready stuck 0 in FETCH -> timeout pulses after 4 waiting cycles, irwrite never asserted, FSM re-enters FETCH, instcount unchanged.
- opcode=111111 in DECODE -> illegal=1 for one cycle, next state 0, instcount unchanged.
- reset_n pulled low during MEMREAD -> immediately state=0, all strobes 0, instcount=0; after release, fetch resumes normally.
